// File: rtl/clint_arb_if.sv
// Request/response port between one bus master and the CLINT arbiter.
// Ports: master drives valid/req/addr/size/wdata/rready and gets ready/rvalid/rdata/resp.
interface clint_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        resp;
    logic              rready;

    modport master (
        output valid, req, addr, size, wdata, rready,
        input  ready, rvalid, rdata, resp
    );

    modport slave (
        input  valid, req, addr, size, wdata, rready,
        output ready, rvalid, rdata, resp
    );
endinterface

// File: rtl/clint_arb.sv
// Two-master round-robin arbiter and single-beat sequencer for the CLINT port.
// Ports: clk, rst (async high); m0_if/m1_if master ports; clint_* CLINT port.
module clint_arb #(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 64,
    parameter logic [ADDR_W-1:0] CLINT_BASE = 64'h0200_0000,
    parameter logic [ADDR_W-1:0] CLINT_MASK = 64'h0000_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    clint_arb_if.slave        m0_if,
    clint_arb_if.slave        m1_if,
    output logic              clint_valid_o,
    output logic              clint_req_o,
    output logic [ADDR_W-1:0] clint_addr_o,
    output logic [1:0]        clint_size_o,
    output logic [DATA_W-1:0] clint_wdata_o,
    input  logic              clint_ready_i,
    input  logic [DATA_W-1:0] clint_rdata_i,
    input  logic [1:0]        clint_resp_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e            state_q;
    logic              last_q;
    logic              gid_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;

    logic              any_v;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic              hit;
    logic              accept;
    logic              rready_g;
    logic              in_resp;

    // On a tie the master not granted last wins; otherwise the lone
    // requester wins (m1 only when m1 alone is valid).
    always_comb begin
        any_v = m0_if.valid | m1_if.valid;
        if (m0_if.valid && m1_if.valid) begin
            win = ~last_q;
        end else begin
            win = m1_if.valid;
        end
        win_addr = win ? m1_if.addr : m0_if.addr;
        hit      = (win_addr & ~CLINT_MASK) == CLINT_BASE;
    end

    // Accept pulse is combinational; masked by rst so every output
    // reads 0 while reset is held.
    assign accept   = (state_q == IDLE) && any_v && !rst;
    assign m0_if.ready = accept && !win;
    assign m1_if.ready = accept && win;

    assign in_resp  = (state_q == RESP);
    assign rready_g = gid_q ? m1_if.rready : m0_if.rready;

    assign m0_if.rvalid = in_resp && !gid_q;
    assign m1_if.rvalid = in_resp && gid_q;
    assign m0_if.rdata  = m0_if.rvalid ? rdata_q : '0;
    assign m1_if.rdata  = m1_if.rvalid ? rdata_q : '0;
    assign m0_if.resp   = m0_if.rvalid ? resp_q : 2'b00;
    assign m1_if.resp   = m1_if.rvalid ? resp_q : 2'b00;

    // The CLINT updates on the write encoding even without valid, so the
    // whole request bus is zeroed outside ISSUE.
    assign clint_valid_o = (state_q == ISSUE);
    assign clint_req_o   = clint_valid_o && req_q;
    assign clint_addr_o  = clint_valid_o ? addr_q : '0;
    assign clint_size_o  = clint_valid_o ? size_q : 2'b00;
    assign clint_wdata_o = clint_valid_o ? wdata_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_v) begin
                        gid_q   <= win;
                        last_q  <= win;
                        req_q   <= win ? m1_if.req : m0_if.req;
                        addr_q  <= win_addr;
                        size_q  <= win ? m1_if.size : m0_if.size;
                        wdata_q <= win ? m1_if.wdata : m0_if.wdata;
                        if (hit) begin
                            state_q <= ISSUE;
                        end else begin
                            state_q <= RESP;
                            rdata_q <= '0;
                            resp_q  <= 2'b11;
                        end
                    end
                end
                ISSUE: begin
                    if (clint_ready_i) begin
                        rdata_q <= req_q ? '0 : clint_rdata_i;
                        resp_q  <= clint_resp_i;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rready_g) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_arb.sv
// Randomized self-checking bench for clint_arb against a transaction-level model.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_clint_arb;
    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam logic [63:0] MASK = 64'h0000_FFFF;
    localparam logic [63:0] KEY  = 64'hA5A5_0000_0000_5A5A;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clint_arb_if #(.ADDR_W(64), .DATA_W(64)) m0_if ();
    clint_arb_if #(.ADDR_W(64), .DATA_W(64)) m1_if ();

    logic        clint_valid_o;
    logic        clint_req_o;
    logic [63:0] clint_addr_o;
    logic [1:0]  clint_size_o;
    logic [63:0] clint_wdata_o;
    logic        clint_ready_i;
    logic [63:0] clint_rdata_i;
    logic [1:0]  clint_resp_i;

    logic        fix_en  = 1'b0;
    logic [63:0] fix_val = '0;

    // CLINT stub: read data and response code derived from the address.
    assign clint_rdata_i = fix_en ? fix_val : (clint_addr_o ^ KEY);
    assign clint_resp_i  = {clint_addr_o[4], 1'b0};

    clint_arb dut (
        .clk           (clk),
        .rst           (rst),
        .m0_if         (m0_if),
        .m1_if         (m1_if),
        .clint_valid_o (clint_valid_o),
        .clint_req_o   (clint_req_o),
        .clint_addr_o  (clint_addr_o),
        .clint_size_o  (clint_size_o),
        .clint_wdata_o (clint_wdata_o),
        .clint_ready_i (clint_ready_i),
        .clint_rdata_i (clint_rdata_i),
        .clint_resp_i  (clint_resp_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (transaction level).
    bit          busy;
    bit          in_resp;
    int          gid;
    int          last;
    txn_t        cur;
    logic [63:0] e_rdata;
    logic [1:0]  e_resp;
    bit          pend [2];
    txn_t        pt [2];
    txn_t        q0 [$];
    txn_t        q1 [$];

    // Stimulus controls.
    bit rnd_req;
    int cr_mode;
    bit rr_rand;
    bit crq [$];
    bit rr0q [$];
    bit crdy;
    bit rr [2];

    // Observation logs.
    int cyc;
    int grant_log [$];
    int lat_log [$];
    int acc_cyc;
    bit prev_rv0, prev_rv1;
    int issue_cnt;
    int rv0_cnt;

    function automatic bit is_hit(input logic [63:0] a);
        return (a & ~MASK) == BASE;
    endfunction

    function automatic logic [63:0] cl_data(input logic [63:0] a);
        return fix_en ? fix_val : (a ^ KEY);
    endfunction

    function automatic logic [1:0] cl_resp(input logic [63:0] a);
        return {a[4], 1'b0};
    endfunction

    function automatic txn_t mk(input logic wr, input logic [63:0] a,
                                input logic [1:0] s, input logic [63:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.size = s; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [63:0] a;
        if ($urandom_range(0, 3) != 0)
            a = BASE | {48'h0, 16'($urandom)};
        else
            a = {$urandom, $urandom};
        return mk(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom});
    endfunction

    task automatic put_inputs();
        m0_if.valid = pend[0];
        m0_if.req   = pt[0].wr;
        m0_if.addr  = pt[0].addr;
        m0_if.size  = pt[0].size;
        m0_if.wdata = pt[0].wdata;
        m1_if.valid = pend[1];
        m1_if.req   = pt[1].wr;
        m1_if.addr  = pt[1].addr;
        m1_if.size  = pt[1].size;
        m1_if.wdata = pt[1].wdata;
        m0_if.rready  = rr[0];
        m1_if.rready  = rr[1];
        clint_ready_i = crdy;
    endtask

    task automatic model_clear();
        busy = 0; in_resp = 0; gid = 0; last = 1;
        pend[0] = 0; pend[1] = 0;
        pt[0] = mk(0, 0, 0, 0); pt[1] = mk(0, 0, 0, 0);
        q0.delete(); q1.delete(); crq.delete(); rr0q.delete();
        rnd_req = 0; cr_mode = 0; rr_rand = 0;
        crdy = 1; rr[0] = 1; rr[1] = 1;
        prev_rv0 = 0; prev_rv1 = 0;
        put_inputs();
    endtask

    task automatic drive();
        if (!pend[0]) begin
            if (q0.size() > 0) begin pt[0] = q0.pop_front(); pend[0] = 1; end
            else if (rnd_req && $urandom_range(0, 2) == 0) begin
                pt[0] = rand_txn(); pend[0] = 1;
            end
        end
        if (!pend[1]) begin
            if (q1.size() > 0) begin pt[1] = q1.pop_front(); pend[1] = 1; end
            else if (rnd_req && $urandom_range(0, 2) == 0) begin
                pt[1] = rand_txn(); pend[1] = 1;
            end
        end
        if (crq.size() > 0) crdy = crq.pop_front();
        else if (cr_mode == 1) crdy = 1'($urandom_range(0, 1));
        else crdy = (cr_mode == 0);
        if (rr0q.size() > 0) rr[0] = rr0q.pop_front();
        else rr[0] = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rr[1] = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        put_inputs();
    endtask

    task automatic monitor(input int w);
        bit ev, erv0, erv1;
        chk("m0_ready", 64'(m0_if.ready), 64'(w == 0));
        chk("m1_ready", 64'(m1_if.ready), 64'(w == 1));
        if (m0_if.ready) begin grant_log.push_back(0); acc_cyc = cyc; end
        if (m1_if.ready) begin grant_log.push_back(1); acc_cyc = cyc; end
        ev = busy && !in_resp;
        chk("clint_valid", 64'(clint_valid_o), 64'(ev));
        chk("clint_req", 64'(clint_req_o), ev ? 64'(cur.wr) : 64'h0);
        chk("clint_addr", clint_addr_o, ev ? cur.addr : 64'h0);
        chk("clint_size", 64'(clint_size_o), ev ? 64'(cur.size) : 64'h0);
        chk("clint_wdata", clint_wdata_o, ev ? cur.wdata : 64'h0);
        if (clint_valid_o) issue_cnt++;
        erv0 = busy && in_resp && gid == 0;
        erv1 = busy && in_resp && gid == 1;
        chk("m0_rvalid", 64'(m0_if.rvalid), 64'(erv0));
        chk("m1_rvalid", 64'(m1_if.rvalid), 64'(erv1));
        chk("rv_excl", 64'(m0_if.rvalid & m1_if.rvalid), 64'h0);
        if (erv0) begin
            chk("m0_rdata", m0_if.rdata, e_rdata);
            chk("m0_resp", 64'(m0_if.resp), 64'(e_resp));
        end
        if (erv1) begin
            chk("m1_rdata", m1_if.rdata, e_rdata);
            chk("m1_resp", 64'(m1_if.resp), 64'(e_resp));
        end
        if (m0_if.rvalid) rv0_cnt++;
        if ((m0_if.rvalid && !prev_rv0) || (m1_if.rvalid && !prev_rv1))
            lat_log.push_back(cyc - acc_cyc);
        prev_rv0 = m0_if.rvalid;
        prev_rv1 = m1_if.rvalid;
    endtask

    task automatic update(input int w);
        if (!busy) begin
            if (w >= 0) begin
                busy = 1; gid = w; last = w; cur = pt[w]; pend[w] = 0;
                if (is_hit(cur.addr)) begin
                    in_resp = 0;
                end else begin
                    in_resp = 1; e_rdata = '0; e_resp = 2'b11;
                end
            end
        end else if (!in_resp) begin
            if (crdy) begin
                in_resp = 1;
                e_rdata = cur.wr ? 64'h0 : cl_data(cur.addr);
                e_resp  = cl_resp(cur.addr);
            end
        end else if (rr[gid]) begin
            busy = 0;
        end
    endtask

    task automatic cycle();
        int w;
        @(negedge clk);
        drive();
        #1;
        w = -1;
        if (!busy) begin
            if (pend[0] && pend[1]) w = 1 - last;
            else if (pend[0]) w = 0;
            else if (pend[1]) w = 1;
        end
        monitor(w);
        update(w);
        cyc++;
    endtask

    task automatic run_quiet(input int maxc);
        int n;
        n = 0;
        while ((busy || pend[0] || pend[1] || q0.size() > 0 || q1.size() > 0)
               && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(n >= maxc), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grant_log.delete(); lat_log.delete();
        issue_cnt = 0; rv0_cnt = 0;
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_cvalid"}, 64'(clint_valid_o), 64'h0);
        chk({p, "_creq"}, 64'(clint_req_o), 64'h0);
        chk({p, "_caddr"}, clint_addr_o, 64'h0);
        chk({p, "_csize"}, 64'(clint_size_o), 64'h0);
        chk({p, "_cwdata"}, clint_wdata_o, 64'h0);
        chk({p, "_m0rdy"}, 64'(m0_if.ready), 64'h0);
        chk({p, "_m1rdy"}, 64'(m1_if.ready), 64'h0);
        chk({p, "_m0rv"}, 64'(m0_if.rvalid), 64'h0);
        chk({p, "_m1rv"}, 64'(m1_if.rvalid), 64'h0);
        chk({p, "_m0rd"}, m0_if.rdata, 64'h0);
        chk({p, "_m1rd"}, m1_if.rdata, 64'h0);
        chk({p, "_m0rs"}, 64'(m0_if.resp), 64'h0);
        chk({p, "_m1rs"}, 64'(m1_if.resp), 64'h0);
    endtask

    initial begin
        cyc = 0; acc_cyc = 0;
        model_clear();
        #1 rst = 1'b1;
        #1 reset_checks("por");
        do_reset();

        // Reset asserted while a write is stalled in ISSUE, m1 pending.
        cr_mode = 2;
        q0.push_back(mk(1, 64'h0200_0008, 2'd3, 64'hDEAD_BEEF));
        cycle();
        cycle();
        q1.push_back(mk(0, 64'h0200_0100, 2'd2, 64'h0));
        cycle();
        chk("pre_rst_cvalid", 64'(clint_valid_o), 64'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_checks("arst");
        do_reset();
        repeat (5) cycle();

        // Single read with a fixed CLINT value.
        do_reset();
        fix_en = 1'b1; fix_val = 64'h1234;
        q0.push_back(mk(0, 64'h0200_BFF8, 2'd3, 64'h0));
        run_quiet(20);
        fix_en = 1'b0;
        chk("rd_lat_n", 64'(lat_log.size()), 64'h1);
        if (lat_log.size() > 0) chk("rd_lat", 64'(lat_log[0]), 64'h2);

        // Round robin with both masters requesting continuously.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, BASE | 64'(i * 8), 2'd3, 64'h0));
            q1.push_back(mk(0, BASE | 64'(16'h100 + i * 8), 2'd3, 64'h0));
        end
        run_quiet(60);
        chk("rr_n", 64'(grant_log.size()), 64'h8);
        foreach (grant_log[i]) chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

        // Write from m1.
        do_reset();
        q1.push_back(mk(1, 64'h0200_4000, 2'd3, 64'h50));
        run_quiet(20);
        chk("wr_issue", 64'(issue_cnt), 64'h1);

        // Decode error.
        do_reset();
        q0.push_back(mk(0, 64'h8000_0000, 2'd2, 64'h0));
        run_quiet(20);
        chk("de_issue", 64'(issue_cnt), 64'h0);
        chk("de_lat_n", 64'(lat_log.size()), 64'h1);
        if (lat_log.size() > 0) chk("de_lat", 64'(lat_log[0]), 64'h1);

        // Backpressure on both the CLINT and the response side.
        do_reset();
        crq  = '{1, 0, 0, 0, 1};
        rr0q = '{1, 1, 1, 1, 1, 0, 0, 1};
        q0.push_back(mk(0, 64'h0200_0010, 2'd3, 64'h0));
        cycle();
        q1.push_back(mk(0, 64'h0200_0020, 2'd3, 64'h0));
        run_quiet(40);
        chk("bp_issue", 64'(issue_cnt), 64'h5);
        chk("bp_rv0", 64'(rv0_cnt), 64'h3);
        chk("bp_n", 64'(grant_log.size()), 64'h2);
        if (grant_log.size() == 2) begin
            chk("bp_g0", 64'(grant_log[0]), 64'h0);
            chk("bp_g1", 64'(grant_log[1]), 64'h1);
        end

        // Random traffic with random backpressure.
        do_reset();
        rnd_req = 1; cr_mode = 1; rr_rand = 1;
        repeat (3000) cycle();
        rnd_req = 0;
        run_quiet(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
